// File: rtl/fetch_ctrl_if.sv
// Bus bundle between the fetch controller, the instruction memory and decode.
// The master side is the fetch controller; the slave side is its environment.
interface fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        halted;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    output if_instr,
    output if_pc,
    input  if_ready,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output if_ready,
    input  halted
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks the PC through a combinational
// instruction memory, buffers up to two fetched {pc, instr} pairs for decode,
// honours redirects with a full flush, and stops after fetching HALT_PC.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] HALT_PC  = 32'h0000_005C
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  fetch_ctrl_if.master bus
);

  localparam logic [0:0]  StRun  = 1'b0;
  localparam logic [0:0]  StHalt = 1'b1;
  localparam logic [31:0] AlignMask      = 32'hFFFF_FFFC;
  localparam logic [31:0] ResetPcAligned = RESET_PC & AlignMask;
  localparam logic [31:0] HaltPcAligned  = HALT_PC & AlignMask;

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [0:0]  state_q, state_d;
  logic [31:0] headPc_q, headPc_d;
  logic [31:0] headInstr_q, headInstr_d;
  logic [31:0] tailPc_q, tailPc_d;
  logic [31:0] tailInstr_q, tailInstr_d;

  logic doPop;
  logic doPush;

  assign doPop  = (count_q != 2'd0) && bus.if_ready;
  assign doPush = !bus.redirect_valid && (state_q == StRun) &&
                  ((count_q != 2'd2) || doPop);

  // Next-state: redirect flushes and retargets; otherwise push/pop the queue.
  always_comb begin
    pc_d        = pc_q;
    count_d     = count_q;
    state_d     = state_q;
    headPc_d    = headPc_q;
    headInstr_d = headInstr_q;
    tailPc_d    = tailPc_q;
    tailInstr_d = tailInstr_q;

    if (bus.redirect_valid) begin
      count_d = 2'd0;
      pc_d    = bus.redirect_pc & AlignMask;
      state_d = StRun;
    end else begin
      if (doPush) begin
        pc_d = pc_q + 32'd4;
        if (pc_q == HaltPcAligned) begin
          state_d = StHalt;
        end
      end

      case ({doPush, doPop})
        2'b11: begin
          if (count_q == 2'd2) begin
            headPc_d    = tailPc_q;
            headInstr_d = tailInstr_q;
            tailPc_d    = pc_q;
            tailInstr_d = bus.imem_data;
          end else begin
            headPc_d    = pc_q;
            headInstr_d = bus.imem_data;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            headPc_d    = pc_q;
            headInstr_d = bus.imem_data;
          end else begin
            tailPc_d    = pc_q;
            tailInstr_d = bus.imem_data;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          headPc_d    = tailPc_q;
          headInstr_d = tailInstr_q;
          count_d     = count_q - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // State registers; reset discards the whole queue immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q        <= ResetPcAligned;
      count_q     <= 2'd0;
      state_q     <= StRun;
      headPc_q    <= 32'd0;
      headInstr_q <= 32'd0;
      tailPc_q    <= 32'd0;
      tailInstr_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      state_q     <= state_d;
      headPc_q    <= headPc_d;
      headInstr_q <= headInstr_d;
      tailPc_q    <= tailPc_d;
      tailInstr_q <= tailInstr_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = (count_q != 2'd0);
  assign bus.if_instr  = headInstr_q;
  assign bus.if_pc     = headPc_q;
  assign bus.halted    = (state_q == StHalt) && (count_q == 2'd0);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a queue-level reference model predicts the
// fetch stream; monitors compare every accepted instruction and status output.
module tb_fetch_ctrl;

  localparam logic [31:0] HaltPc = 32'h0000_005C;
  localparam logic [31:0] ResetPc = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic rst2_ni = 1'b0;

  fetch_ctrl_if bus();
  fetch_ctrl_if bus2();

  fetch_ctrl #(.RESET_PC(ResetPc), .HALT_PC(HaltPc)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus.master)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .HALT_PC(32'h0000_0F00)) dutWrap (
    .clk_i(clk), .rst_ni(rst2_ni), .bus(bus2.master)
  );

  // Instruction memory returns the word index of the address.
  assign bus.imem_data  = bus.imem_addr >> 2;
  assign bus2.imem_data = bus2.imem_addr >> 2;

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: expected queue contents, PC and halt flag.
  entry_t expQ[$];
  entry_t expQ2[$];
  logic [31:0] mPc = ResetPc;
  logic mHalt = 1'b0;
  logic [31:0] lastPopPc = 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Main monitor: status every cycle, and each accepted instruction popped.
  always @(negedge clk) begin
    entry_t e;
    checkOutput("imem_addr", bus.imem_addr, mPc);
    checkOutput("if_valid", {31'd0, bus.if_valid}, {31'd0, expQ.size() != 0});
    checkOutput("halted", {31'd0, bus.halted}, {31'd0, mHalt && (expQ.size() == 0)});
    if (bus.if_valid && bus.if_ready) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_pop: got pc %h expected no entry", bus.if_pc);
      end else begin
        e = expQ.pop_front();
        checkOutput("if_pc", bus.if_pc, e.pc);
        checkOutput("if_instr", bus.if_instr, e.instr);
        lastPopPc = bus.if_pc;
      end
    end
  end

  // Wrap-around monitor for the second instance.
  always @(negedge clk) begin
    entry_t e;
    if (bus2.if_valid && bus2.if_ready) begin
      if (expQ2.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL wrap_unexpected_pop: got pc %h expected no entry", bus2.if_pc);
      end else begin
        e = expQ2.pop_front();
        checkOutput("wrap_if_pc", bus2.if_pc, e.pc);
        checkOutput("wrap_if_instr", bus2.if_instr, e.instr);
      end
    end
  end

  // Called at posedge+2: drive one cycle of inputs, advance the model at +8,
  // return at the next posedge+2.
  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
    entry_t e;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.if_ready       = rdy;
    #6;
    if (rv) begin
      expQ.delete();
      mPc   = rpc & 32'hFFFF_FFFC;
      mHalt = 1'b0;
    end else if (!mHalt && expQ.size() < 2) begin
      e.pc = mPc;
      e.instr = mPc >> 2;
      expQ.push_back(e);
      if (mPc == HaltPc) mHalt = 1'b1;
      mPc = mPc + 32'd4;
    end
    @(posedge clk);
    #2;
  endtask

  // Called at posedge+2: assert reset mid-cycle, check it acts at once,
  // hold it across two edges and release at posedge+2.
  task automatic doReset();
    #1;
    rst_ni = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.if_ready = 1'b0;
    expQ.delete();
    mPc = ResetPc;
    mHalt = 1'b0;
    #1;
    checkOutput("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    checkOutput("rst_if_pc", bus.if_pc, 32'd0);
    checkOutput("rst_if_instr", bus.if_instr, 32'd0);
    checkOutput("rst_imem_addr", bus.imem_addr, ResetPc);
    checkOutput("rst_halted", {31'd0, bus.halted}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    entry_t e;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.if_ready = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc = 32'd0;
    bus2.if_ready = 1'b0;
    @(posedge clk);
    #2;

    // PC wrap on the second instance while the main instance stays in reset.
    checkOutput("wrap_rst_valid", {31'd0, bus2.if_valid}, 32'd0);
    checkOutput("wrap_rst_addr", bus2.imem_addr, 32'hFFFF_FFF8);
    e.pc = 32'hFFFF_FFF8; e.instr = 32'h3FFF_FFFE; expQ2.push_back(e);
    e.pc = 32'hFFFF_FFFC; e.instr = 32'h3FFF_FFFF; expQ2.push_back(e);
    e.pc = 32'h0000_0000; e.instr = 32'h0000_0000; expQ2.push_back(e);
    bus2.if_ready = 1'b1;
    rst2_ni = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("wrap_all_seen", expQ2.size(), 32'd0);
    checkOutput("wrap_valid_before_rst", {31'd0, bus2.if_valid}, 32'd1);
    #1;
    rst2_ni = 1'b0;
    #1;
    checkOutput("wrap_async_rst_valid", {31'd0, bus2.if_valid}, 32'd0);
    checkOutput("wrap_async_rst_pc", bus2.if_pc, 32'd0);
    bus2.if_ready = 1'b0;
    @(posedge clk);
    #2;

    // Streaming from reset with decode always ready.
    doReset();
    repeat (8) applyStimulus(1'b0, 32'd0, 1'b1);

    // Stall after reset until the queue is full, then drain in order.
    doReset();
    repeat (5) applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("stall_pc", bus.imem_addr, 32'h8);
    repeat (4) applyStimulus(1'b0, 32'd0, 1'b1);

    // Redirect to an unaligned target while the queue is full.
    repeat (3) applyStimulus(1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0043, 1'b0);
    repeat (3) applyStimulus(1'b0, 32'd0, 1'b1);

    // Run into the halt address and drain.
    repeat (30) applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("last_pc", lastPopPc, HaltPc);
    checkOutput("halted_final", {31'd0, bus.halted}, 32'd1);
    checkOutput("halt_addr_hold", bus.imem_addr, HaltPc + 32'd4);

    // Redirect out of halt.
    applyStimulus(1'b1, 32'h0000_0010, 1'b1);
    repeat (4) applyStimulus(1'b0, 32'd0, 1'b1);

    // Randomized traffic with occasional redirects and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(127) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(15) == 0, $urandom & 32'h7F, $urandom_range(3) != 0);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
